dtw_controller: RTL and testbench

DTW_CONTROLLER -- requirements
Module: dtw_controller

---
 rtl/dtw_pkg.sv | 18 +
 rtl/dtw_index_counter.sv | 54 +++++
 rtl/dtw_controller.sv | 154 +++++++++++++++
 tb/tb_dtw_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW cell-sequencing controller:
// default parameters, index width and the FSM state encoding.
package dtw_pkg;

  localparam int MAX_LEN_DEF     = 16;
  localparam int COST_W_DEF      = 6;
  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int IDX_W           = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } dtw_state_e;

endpackage

// File: rtl/dtw_index_counter.sv
// Row-major (i,j) walker over an N x N cost matrix; last flags the final cell.
module dtw_index_counter
  import dtw_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clear_i,
  input  logic [W-1:0] len_i,
  output logic [W-1:0] i_o,
  output logic [W-1:0] j_o,
  output logic         last_o
);

  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] len_m1;

  assign len_m1 = len_i - W'(1);

  // clear wins over inc so a fresh run always starts from (0,0)
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
    end else if (inc_i) begin
      if (j_q == len_m1) begin
        j_d = '0;
        i_d = i_q + W'(1);
      end else begin
        j_d = j_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign last_o = (i_q == len_m1) && (j_q == len_m1);

endmodule

// File: rtl/dtw_controller.sv
// Sequences the DTW cell datapath over an N x N matrix in row-major order,
// with a request/ack handshake, ack timeout and final-distance capture.
module dtw_controller
  import dtw_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int COST_W      = COST_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [IDX_W-1:0]  seq_len,
  output logic [IDX_W-1:0]  addr_sample,
  output logic [IDX_W-1:0]  addr_test,
  output logic              cell_req,
  output logic              cell_first_row,
  output logic              cell_first_col,
  input  logic              cell_ack,
  input  logic [COST_W-1:0] cell_cost,
  output logic              busy,
  output logic              valid,
  output logic [COST_W-1:0] Out_Euclidean_Distatnce,
  output logic              err
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  dtw_state_e        state_q;
  logic [IDX_W-1:0]  len_q;
  logic [WAIT_W-1:0] wait_q;
  logic              cell_req_q;
  logic              busy_q;
  logic              valid_q;
  logic              err_q;
  logic [COST_W-1:0] dist_q;

  logic [IDX_W-1:0]  idx_i;
  logic [IDX_W-1:0]  idx_j;
  logic              idx_last;
  logic              idx_clear;
  logic              idx_inc;
  logic              start_ok;

  assign start_ok = (seq_len != '0) && (int'(seq_len) < MAX_LEN);

  always_comb begin
    idx_clear = 1'b0;
    idx_inc   = 1'b0;
    if (state_q == IDLE && Start && start_ok)
      idx_clear = 1'b1;
    if (state_q == REQ && cell_ack && !idx_last)
      idx_inc = 1'b1;
  end

  dtw_index_counter #(
    .W(IDX_W)
  ) u_index (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (idx_inc),
    .clear_i(idx_clear),
    .len_i  (len_q),
    .i_o    (idx_i),
    .j_o    (idx_j),
    .last_o (idx_last)
  );

  // Outputs are registered alongside the state so they change exactly on transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wait_q     <= '0;
      cell_req_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      dist_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          if (Start) begin
            busy_q <= 1'b1;
            wait_q <= '0;
            if (start_ok) begin
              len_q      <= seq_len;
              cell_req_q <= 1'b1;
              state_q    <= REQ;
            end else begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        REQ: begin
          if (cell_ack) begin
            cell_req_q <= 1'b0;
            wait_q     <= '0;
            if (idx_last) begin
              dist_q  <= cell_cost;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= GAP;
            end
          end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
            // Datapath never answered: abort the run without touching the distance
            cell_req_q <= 1'b0;
            wait_q     <= '0;
            err_q      <= 1'b1;
            state_q    <= ERR;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        GAP: begin
          cell_req_q <= 1'b1;
          state_q    <= REQ;
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cell_req_q <= 1'b0;
          busy_q     <= 1'b0;
          valid_q    <= 1'b0;
          err_q      <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign addr_sample             = idx_i;
  assign addr_test               = idx_j;
  assign cell_req                = cell_req_q;
  assign cell_first_row          = cell_req_q && (idx_i == '0);
  assign cell_first_col          = cell_req_q && (idx_j == '0);
  assign busy                    = busy_q;
  assign valid                   = valid_q;
  assign err                     = err_q;
  assign Out_Euclidean_Distatnce = dist_q;

endmodule

// File: tb/tb_dtw_controller.sv
// Directed self-checking bench for dtw_controller; inputs driven and outputs
// sampled on the falling clock edge.
module tb_dtw_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [3:0] seq_len;
  logic [3:0] addr_sample;
  logic [3:0] addr_test;
  logic       cell_req;
  logic       cell_first_row;
  logic       cell_first_col;
  logic       cell_ack;
  logic [5:0] cell_cost;
  logic       busy;
  logic       valid;
  logic [5:0] Out_Euclidean_Distatnce;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  dtw_controller dut (
    .clk                    (clk),
    .rst                    (rst),
    .Start                  (Start),
    .seq_len                (seq_len),
    .addr_sample            (addr_sample),
    .addr_test              (addr_test),
    .cell_req               (cell_req),
    .cell_first_row         (cell_first_row),
    .cell_first_col         (cell_first_col),
    .cell_ack               (cell_ack),
    .cell_cost              (cell_cost),
    .busy                   (busy),
    .valid                  (valid),
    .Out_Euclidean_Distatnce(Out_Euclidean_Distatnce),
    .err                    (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] len, input logic a, input logic [5:0] c);
    Start     = s;
    seq_len   = len;
    cell_ack  = a;
    cell_cost = c;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " req"}, 32'(cell_req), 32'd0);
    checkOutput({tag, " valid"}, 32'(valid), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
  endtask

  // Entered on the falling edge where the cell request is expected; leaves on
  // the falling edge of the next request (or after the post-valid idle cycle).
  task automatic runCell(input int i, input int j, input int delay, input logic [5:0] cost, input bit last);
    string tag;
    tag = $sformatf("cell(%0d,%0d)", i, j);
    checkOutput({tag, " req"}, 32'(cell_req), 32'd1);
    checkOutput({tag, " addr_sample"}, 32'(addr_sample), 32'(i));
    checkOutput({tag, " addr_test"}, 32'(addr_test), 32'(j));
    checkOutput({tag, " first_row"}, 32'(cell_first_row), 32'(i == 0));
    checkOutput({tag, " first_col"}, 32'(cell_first_col), 32'(j == 0));
    cell_ack = 1'b0;
    repeat (delay) @(negedge clk);
    if (delay > 0) begin
      checkOutput({tag, " req held"}, 32'(cell_req), 32'd1);
      checkOutput({tag, " addr stable"}, 32'({addr_sample, addr_test}), 32'(i * 16 + j));
    end
    cell_ack  = 1'b1;
    cell_cost = cost;
    @(negedge clk);
    cell_ack = 1'b0;
    if (last) begin
      checkOutput({tag, " valid"}, 32'(valid), 32'd1);
      checkOutput({tag, " distance"}, 32'(Out_Euclidean_Distatnce), 32'(cost));
      checkOutput({tag, " req after last"}, 32'(cell_req), 32'd0);
      @(negedge clk);
      checkIdle({tag, " post-done"});
    end else begin
      checkOutput({tag, " gap req"}, 32'(cell_req), 32'd0);
      checkOutput({tag, " gap valid"}, 32'(valid), 32'd0);
      checkOutput({tag, " gap busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] lastCost;
    int         k;

    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 6'd0);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset distance", 32'(Out_Euclidean_Distatnce), 32'd0);
    checkOutput("reset addr", 32'({addr_sample, addr_test}), 32'd0);
    checkOutput("reset first_row", 32'(cell_first_row), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("after release");

    // N=2 with immediate acks: req on cycles 1,3,5,7 and valid on cycle 8
    applyStimulus(1'b1, 4'd2, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    runCell(0, 0, 0, 6'd1, 1'b0);
    runCell(0, 1, 0, 6'd2, 1'b0);
    runCell(1, 0, 0, 6'd2, 1'b0);
    runCell(1, 1, 0, 6'd3, 1'b1);

    // Zero length: one-cycle error, no request
    applyStimulus(1'b1, 4'd0, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    checkOutput("len0 err", 32'(err), 32'd1);
    checkOutput("len0 busy", 32'(busy), 32'd1);
    checkOutput("len0 req", 32'(cell_req), 32'd0);
    checkOutput("len0 distance", 32'(Out_Euclidean_Distatnce), 32'd3);
    @(negedge clk);
    checkIdle("len0 after");

    // N=3, ack withheld on (1,1) until timeout
    applyStimulus(1'b1, 4'd3, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    runCell(0, 0, 0, 6'd10, 1'b0);
    runCell(0, 1, 2, 6'd11, 1'b0);
    runCell(0, 2, 0, 6'd12, 1'b0);
    runCell(1, 0, 0, 6'd13, 1'b0);
    checkOutput("timeout cell req", 32'(cell_req), 32'd1);
    checkOutput("timeout cell addr", 32'({addr_sample, addr_test}), 32'h11);
    cell_ack = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("timeout req still high", 32'(cell_req), 32'd1);
    checkOutput("timeout no early err", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("timeout err", 32'(err), 32'd1);
    checkOutput("timeout req dropped", 32'(cell_req), 32'd0);
    checkOutput("timeout valid", 32'(valid), 32'd0);
    checkOutput("timeout distance kept", 32'(Out_Euclidean_Distatnce), 32'd3);
    @(negedge clk);
    checkIdle("timeout after");

    // N=4 with Start re-pulsed and seq_len changed mid-run
    applyStimulus(1'b1, 4'd4, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) begin
        Start   = 1'b1;
        seq_len = 4'd1;
      end
      if (c == 8) Start = 1'b0;
      runCell(c / 4, c % 4, 0, 6'(c + 10), c == 15);
    end
    checkOutput("n4 distance", 32'(Out_Euclidean_Distatnce), 32'd25);
    @(negedge clk);
    checkIdle("n4 no second valid");

    // N=5, reset while requesting (0,2), then a fresh N=1 run
    applyStimulus(1'b1, 4'd5, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    runCell(0, 0, 0, 6'd4, 1'b0);
    runCell(0, 1, 0, 6'd5, 1'b0);
    checkOutput("pre-reset req", 32'(cell_req), 32'd1);
    checkOutput("pre-reset addr_test", 32'(addr_test), 32'd2);
    rst = 1'b1;
    #1;
    checkIdle("async reset");
    checkOutput("async reset distance", 32'(Out_Euclidean_Distatnce), 32'd0);
    checkOutput("async reset addr", 32'({addr_sample, addr_test}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkIdle("reset held");
    @(negedge clk);
    checkIdle("reset released");
    applyStimulus(1'b1, 4'd1, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    runCell(0, 0, 0, 6'd9, 1'b1);

    // N=15 with random ack delays 0..14
    applyStimulus(1'b1, 4'd15, 1'b0, 6'd0);
    @(negedge clk);
    Start = 1'b0;
    lastCost = 6'd0;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 15; j++) begin
        lastCost = 6'($urandom_range(0, 63));
        runCell(i, j, int'($urandom_range(0, 14)), lastCost, (i == 14) && (j == 14));
        k++;
      end
    end
    checkOutput("n15 cell count", 32'(k), 32'd225);
    checkOutput("n15 distance", 32'(Out_Euclidean_Distatnce), 32'(lastCost));
    @(negedge clk);
    checkIdle("n15 no second valid");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
